// File: rtl/ram_port_arbiter_if.sv
// Bundles the I-port, D-port and RAM-side signals of the data RAM arbiter.
// The arbiter uses "slave"; requesters and the RAM model use "master".
interface ram_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        m_cs;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_din;
    logic [31:0] m_dout;
    logic        m_stall;
    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_dout, m_stall,
        output i_rdata, i_stall, d_rdata, d_stall, m_cs, m_we, m_addr, m_din, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_dout, m_stall,
        input  i_rdata, i_stall, d_rdata, d_stall, m_cs, m_we, m_addr, m_din, err
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto the single-ported,
// multi-cycle data RAM, holding each access stable until the RAM drops its stall.
//
// state | meaning
// IDLE  | no access; arbitrate pending requests
// BUSY  | access driven to the RAM, waiting for m_stall low or timeout
// DONE  | owner's stall released, rdata valid, address parked at IDLE_ADDR
// GAP   | address held at IDLE_ADDR so the RAM restarts its access counter
module ram_port_arbiter #(
    parameter logic [31:0] IDLE_ADDR    = 32'hFFFF_FFFF,
    parameter int          STARVE_LIMIT = 4,
    parameter int          TIMEOUT      = 64
) (
    input logic                clk,
    input logic                rst,
    ram_port_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          owner_d;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;
    logic          cs_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   din_q;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          err_q;
    logic          i_wins;
    logic          finish;
    logic [31:0]   done_data;

    assign i_wins    = bus.i_req && (!bus.d_req || starve_cnt == STARVE_MAX);
    assign finish    = !bus.m_stall || to_cnt == TO_LAST;
    // A timed-out access returns zero rather than whatever the RAM is driving.
    assign done_data = bus.m_stall ? 32'd0 : bus.m_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner_d    <= 1'b0;
            starve_cnt <= '0;
            to_cnt     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= IDLE_ADDR;
            din_q      <= 32'd0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        cs_q   <= 1'b1;
                        to_cnt <= '0;
                        state  <= S_BUSY;
                        if (i_wins) begin
                            owner_d    <= 1'b0;
                            addr_q     <= bus.i_addr;
                            we_q       <= 1'b0;
                            din_q      <= 32'd0;
                            starve_cnt <= '0;
                        end else begin
                            owner_d <= 1'b1;
                            addr_q  <= bus.d_addr;
                            we_q    <= bus.d_we;
                            din_q   <= bus.d_wdata;
                            if (!bus.i_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (finish) begin
                        if (owner_d)
                            d_rdata_q <= done_data;
                        else
                            i_rdata_q <= done_data;
                        if (bus.m_stall)
                            err_q <= 1'b1;
                        cs_q   <= 1'b0;
                        we_q   <= 1'b0;
                        addr_q <= IDLE_ADDR;
                        state  <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_GAP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.m_cs    = cs_q;
    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_din   = din_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;
    assign bus.i_stall = bus.i_req && !(state == S_DONE && !owner_d);
    assign bus.d_stall = bus.d_req && !(state == S_DONE && owner_d);
endmodule
